half_divide_arbiter: RTL and testbench

//  Shares one pipelined half-precision divider among N_REQ requesters.

---
 rtl/hdiv_arb_pkg.sv | 19 +
 rtl/hdiv_tag_fifo.sv | 57 +++++
 rtl/half_divide_arbiter.sv | 134 +++++++++++++
 tb/tb_half_divide_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdiv_arb_pkg.sv
// Shared constants and helpers for the half-precision divider arbiter.
package hdiv_arb_pkg;

  localparam int HALF_W = 16;
  localparam logic [HALF_W-1:0] HALF_ONE  = 16'h3C00;
  localparam logic [HALF_W-1:0] HALF_ZERO = 16'h0000;

  // Wide enough for any requester index up to 8 requesters.
  localparam int PTR_W = 3;

  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                               input int unsigned n_req);
    logic [PTR_W:0] nxt;
    nxt = {1'b0, ptr} + (PTR_W+1)'(1);
    if (nxt >= (PTR_W+1)'(n_req)) nxt = '0;
    return nxt[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/hdiv_tag_fifo.sv
// In-order queue of requester IDs for operations currently inside the divider.
module hdiv_tag_fifo
  import hdiv_arb_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     empty,
  output logic                     full,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en, pop_en;

  // A pop frees a slot in the same cycle, so a full queue can still accept a push.
  always_comb begin
    pop_en   = pop & (count_q != '0);
    push_en  = push & ((count_q != (AW+1)'(DEPTH)) | pop_en);
    wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/half_divide_arbiter.sv
// Round-robin front end sharing one pipelined half-precision divider among
// N_REQ clients, with credit limiting and in-order result routing.
module half_divide_arbiter
  import hdiv_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [HALF_W*N_REQ-1:0]       req_a,
  input  logic [HALF_W*N_REQ-1:0]       req_b,
  output logic [N_REQ-1:0]              resp_valid,
  output logic [HALF_W-1:0]             resp_c,
  output logic                          div_in_valid,
  output logic [HALF_W-1:0]             div_a,
  output logic [HALF_W-1:0]             div_b,
  input  logic                          div_out_valid,
  input  logic [HALF_W-1:0]             div_c,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err_underflow
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]  winner, head_tag;
  logic              found, can_issue, handshake, credit_ret;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  unused_fifo_count;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              div_in_valid_q, div_in_valid_d;
  logic [HALF_W-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [HALF_W-1:0] resp_c_q, resp_c_d;
  logic              err_q, err_d;
  int                idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = TAG_W'(idx);
      end
    end
  end

  // A result leaving the divider returns its credit in the same cycle, so a
  // full window keeps issuing at one per cycle with push and pop together.
  assign credit_ret = div_out_valid & ~fifo_empty;
  assign can_issue  = ((inflight_q < CNT_W'(MAX_INFLIGHT)) & ~fifo_full) | credit_ret;
  assign handshake  = found & can_issue;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[winner] = 1'b1;
  end

  always_comb begin
    rr_ptr_d       = handshake ? TAG_W'(rr_next(PTR_W'(winner), N_REQ)) : rr_ptr_q;
    div_in_valid_d = handshake;
    div_a_d        = handshake ? req_a[winner*HALF_W +: HALF_W] : div_a_q;
    div_b_d        = handshake ? req_b[winner*HALF_W +: HALF_W] : div_b_q;

    case ({handshake, credit_ret})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    resp_valid_d = '0;
    resp_c_d     = resp_c_q;
    if (credit_ret) begin
      resp_valid_d[head_tag] = 1'b1;
      resp_c_d               = div_c;
    end

    // A result with no matching tag is dropped and flagged until reset.
    err_d = err_q | (div_out_valid & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q       <= '0;
      div_in_valid_q <= 1'b0;
      div_a_q        <= HALF_ZERO;
      div_b_q        <= HALF_ZERO;
      inflight_q     <= '0;
      resp_valid_q   <= '0;
      resp_c_q       <= HALF_ZERO;
      err_q          <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      div_in_valid_q <= div_in_valid_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      inflight_q     <= inflight_d;
      resp_valid_q   <= resp_valid_d;
      resp_c_q       <= resp_c_d;
      err_q          <= err_d;
    end
  end

  hdiv_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (handshake),
    .push_data (winner),
    .pop       (credit_ret),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head      (head_tag),
    .count     (unused_fifo_count)
  );

  assign div_in_valid  = div_in_valid_q;
  assign div_a         = div_a_q;
  assign div_b         = div_b_q;
  assign inflight      = inflight_q;
  assign resp_valid    = resp_valid_q;
  assign resp_c        = resp_c_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_half_divide_arbiter.sv
// Bench for half_divide_arbiter: a fixed-latency divider stand-in feeds a
// transaction-level scoreboard; a second, 4-credit instance exercises the credit limit.
module tb_half_divide_arbiter;
  import hdiv_arb_pkg::*;

  localparam int N   = 4;
  localparam int L   = 12;
  localparam int MAX = 32;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  req_valid, req_ready, resp_valid;
  logic [63:0]   req_a, req_b;
  logic [15:0]   resp_c, div_a, div_b, div_c;
  logic          div_in_valid, div_out_valid, err_underflow;
  logic [5:0]    inflight;
  logic          force_out;

  logic [N-1:0]  s_req_valid, s_req_ready, s_resp_valid;
  logic [63:0]   s_req_a, s_req_b;
  logic [15:0]   s_resp_c, s_div_a, s_div_b, s_div_c;
  logic          s_div_in_valid, s_div_out_valid, s_err_underflow;
  logic [2:0]    s_inflight;

  int n_checks = 0;
  int n_fail   = 0;

  half_divide_arbiter #(.N_REQ(N), .MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_c(resp_c),
    .div_in_valid(div_in_valid), .div_a(div_a), .div_b(div_b),
    .div_out_valid(div_out_valid), .div_c(div_c), .inflight(inflight),
    .err_underflow(err_underflow)
  );

  half_divide_arbiter #(.N_REQ(N), .MAX_INFLIGHT(4)) dut_small (
    .clk(clk), .rstn(rstn), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_req_a), .req_b(s_req_b), .resp_valid(s_resp_valid), .resp_c(s_resp_c),
    .div_in_valid(s_div_in_valid), .div_a(s_div_a), .div_b(s_div_b),
    .div_out_valid(s_div_out_valid), .div_c(s_div_c), .inflight(s_inflight),
    .err_underflow(s_err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stand-in: exact for the directed operand pairs, a fixed scramble otherwise.
  function automatic logic [15:0] div_ref(input logic [15:0] a, input logic [15:0] b);
    if (a == HALF_ZERO) return HALF_ZERO;
    if (b == HALF_ONE) return a;
    if (a == 16'h4600 && b == 16'h4200) return 16'h4000;
    return {a[7:0], b[15:8]} ^ 16'h5A5A;
  endfunction

  logic [L-1:0] pipe_v;
  logic [15:0]  pipe_c [L];

  always @(posedge clk) begin
    if (!rstn) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[L-2:0], div_in_valid};
      pipe_c[0] <= div_ref(div_a, div_b);
      for (int i = 1; i < L; i++) pipe_c[i] <= pipe_c[i-1];
    end
  end

  assign div_out_valid = pipe_v[L-1] | force_out;
  assign div_c         = force_out ? 16'hDEAD : pipe_c[L-1];

  typedef struct {
    int          due;
    int          id;
    logic [15:0] c;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          rr  = 0;
  logic        exp_in_valid = 1'b0;
  logic [15:0] exp_a = 16'h0, exp_b = 16'h0, exp_resp_c = 16'h0;
  logic        err_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [63:0] a, input logic [63:0] b);
    req_valid = v;
    req_a     = a;
    req_b     = b;
  endtask

  // Checks every main-instance output against the scoreboard, then advances it.
  task automatic checkOutput();
    int         outstanding, win, id, ri;
    bit         found, can, due_now, ret_now;
    logic [N-1:0] exp_ready, exp_rv;
    @(negedge clk);
    due_now     = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    ri          = due_now ? 1 : 0;
    ret_now     = (exp_q.size() > ri) && (exp_q[ri].due == cyc + 1);
    outstanding = exp_q.size() - ri;
    can         = (outstanding < MAX) || ret_now;
    found = 0;
    win   = 0;
    for (int k = 0; k < N; k++) begin
      id = (rr + k) % N;
      if (!found && req_valid[id]) begin
        found = 1;
        win   = id;
      end
    end
    exp_ready = '0;
    if (found && can) exp_ready[win] = 1'b1;
    exp_rv = '0;
    if (due_now) begin
      exp_rv[exp_q[0].id] = 1'b1;
      exp_resp_c          = exp_q[0].c;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("inflight", 32'(inflight), 32'(outstanding));
    chk("div_in_valid", 32'(div_in_valid), 32'(exp_in_valid));
    chk("div_a", 32'(div_a), 32'(exp_a));
    chk("div_b", 32'(div_b), 32'(exp_b));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    chk("resp_c", 32'(resp_c), 32'(exp_resp_c));
    chk("err_underflow", 32'(err_underflow), 32'(err_exp));

    if (due_now) exp_q.delete(0);
    if (found && can) begin
      exp_q.push_back('{due: cyc + 2 + L, id: win,
                        c: div_ref(req_a[win*16 +: 16], req_b[win*16 +: 16])});
      rr           = (win + 1) % N;
      exp_in_valid = 1'b1;
      exp_a        = req_a[win*16 +: 16];
      exp_b        = req_b[win*16 +: 16];
    end else begin
      exp_in_valid = 1'b0;
    end
    if (force_out && outstanding == 0) err_exp = 1'b1;
    if (!rstn) begin
      exp_q.delete();
      rr           = 0;
      exp_in_valid = 1'b0;
      exp_a        = 16'h0;
      exp_b        = 16'h0;
      exp_resp_c   = 16'h0;
      err_exp      = 1'b0;
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput();
      advance();
    end
  endtask

  initial begin
    rstn            = 1'b0;
    force_out       = 1'b0;
    applyStimulus('0, '0, '0);
    s_req_valid     = '0;
    s_req_a         = '0;
    s_req_b         = '0;
    s_div_out_valid = 1'b0;
    s_div_c         = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    cycles(1);
    rstn = 1'b1;
    cycles(1);

    $display("[TB] single operations");
    applyStimulus(4'b0001, {48'h0, 16'h4000}, {48'h0, 16'h3C00});
    cycles(1);
    applyStimulus('0, '0, '0);
    cycles(L + 3);
    applyStimulus(4'b0100, {16'h0, 16'h4600, 32'h0}, {16'h0, 16'h4200, 32'h0});
    cycles(1);
    applyStimulus(4'b0010, 64'h0, {32'h0, 16'h4400, 16'h0});
    cycles(1);
    applyStimulus('0, '0, '0);
    cycles(L + 3);

    $display("[TB] round robin, all requesters");
    applyStimulus(4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    cycles(9);
    applyStimulus('0, '0, '0);
    cycles(L + 3);

    $display("[TB] credit limit on 4-credit instance");
    s_req_valid = 4'hF;
    s_req_a     = {$urandom, $urandom};
    s_req_b     = {$urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      checkOutput();
      chk("small_ready", 32'(s_req_ready), (i < 4) ? (32'd1 << i) : 32'd0);
      chk("small_inflight", 32'(s_inflight), (i < 4) ? 32'(i) : 32'd4);
      advance();
    end
    s_div_out_valid = 1'b1;
    s_div_c         = 16'h1234;
    checkOutput();
    chk("small_ready_on_return", 32'(s_req_ready), 32'd1);
    advance();
    s_div_out_valid = 1'b0;
    s_req_valid     = '0;
    checkOutput();
    chk("small_inflight_after_swap", 32'(s_inflight), 32'd4);
    chk("small_resp_valid", 32'(s_resp_valid), 32'd1);
    chk("small_resp_c", 32'(s_resp_c), 32'h1234);
    advance();

    $display("[TB] reset with operations in flight");
    applyStimulus(4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    cycles(10);
    applyStimulus('0, '0, '0);
    rstn = 1'b0;
    cycles(1);
    rstn = 1'b1;
    checkOutput();
    chk("inflight_after_reset", 32'(inflight), 32'd0);
    chk("small_inflight_after_reset", 32'(s_inflight), 32'd0);
    advance();
    cycles(L + 4);

    $display("[TB] underflow");
    force_out = 1'b1;
    cycles(1);
    force_out = 1'b0;
    checkOutput();
    chk("err_set", 32'(err_underflow), 32'd1);
    chk("err_no_resp", 32'(resp_valid), 32'd0);
    chk("err_inflight", 32'(inflight), 32'd0);
    advance();

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      cycles(1);
    end
    applyStimulus('0, '0, '0);
    cycles(L + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
